// File: rtl/imm_share_arb.sv
// Two-port round-robin arbiter sharing one RV64 immediate decoder, with a
// single registered response slot and valid/ready handshakes on every port.

module imm (
    input  logic [31:0] inst_i,
    output logic [63:0] imm_o
);
    logic [6:0] opcode;

    always_comb begin
        imm_o  = '0;
        opcode = inst_i[6:0];
        case (opcode)
            7'b0110111, 7'b0010111:                       // LUI, AUIPC
                imm_o = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
            7'b0010011, 7'b0000011, 7'b1100111:           // OP-IMM, LOAD, JALR
                imm_o = {{52{inst_i[31]}}, inst_i[31:20]};
            7'b0100011:                                   // STORE
                imm_o = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            7'b1100011:                                   // BRANCH
                imm_o = {{52{inst_i[31]}}, inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            7'b1101111:                                   // JAL
                imm_o = {{44{inst_i[31]}}, inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end
endmodule

module imm_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_inst,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_inst,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_imm,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag
);
    logic             rsp_valid_q, rsp_valid_d;
    logic [63:0]      rsp_imm_q,   rsp_imm_d;
    logic             rsp_src_q,   rsp_src_d;
    logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
    logic             ptr_q,       ptr_d;

    logic             can_accept;
    logic             acc0, acc1, accept, both_valid;
    logic [31:0]      sel_inst;
    logic [63:0]      dec_imm;

    imm u_imm (
        .inst_i (sel_inst),
        .imm_o  (dec_imm)
    );

    // Each ready is built only from the other port's valid and the pointer,
    // so no requester sees its own valid looped back into its ready.
    always_comb begin
        can_accept = !rst && !flush && (!rsp_valid_q || rsp_ready);
        req0_ready = can_accept && (!req1_valid || !ptr_q);
        req1_ready = can_accept && (!req0_valid ||  ptr_q);
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        accept     = acc0 || acc1;
        both_valid = req0_valid && req1_valid;
        sel_inst   = acc1 ? req1_inst : req0_inst;
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_imm_d   = rsp_imm_q;
        rsp_src_d   = rsp_src_q;
        rsp_tag_d   = rsp_tag_q;
        ptr_d       = ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_imm_d   = dec_imm;
            rsp_src_d   = acc1;
            rsp_tag_d   = acc1 ? req1_tag : req0_tag;
            if (both_valid) begin
                ptr_d = acc0;
            end
        end else if (flush || rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_imm_q   <= '0;
            rsp_src_q   <= 1'b0;
            rsp_tag_q   <= '0;
            ptr_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_imm_q   <= rsp_imm_d;
            rsp_src_q   <= rsp_src_d;
            rsp_tag_q   <= rsp_tag_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_imm   = rsp_imm_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
endmodule
